uart_tx_serializer: RTL and testbench

UART transmit serializer. It pops bytes from the TX FIFO over a valid/ready handshake and drives the serial `tx_o` line with start, data, optional parity and stop bits at a programmable bit period. It sits directly downstream of the TX FIFO's read port, inside the APB UART, and takes its configuration from the UART register block.

---
 rtl/uart_tx_serializer.sv | 217 +++++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit serializer. Pops bytes from the TX FIFO read port over a
// valid/ready handshake and shifts them out on a registered serial line as
// start bit, 5..8 data bits (LSB first), optional parity and one or two stop
// bits, each bit lasting cfg_div_i+1 clock cycles.
//
// Ports
//   clk_i             clock
//   rst_i             synchronous, active-high reset
//   cfg_en_i          transmitter enable (gates acceptance of new bytes only)
//   cfg_div_i[15:0]   bit period minus one, in clk_i cycles
//   cfg_bits_i[1:0]   data bits: 0=5, 1=6, 2=7, 3=8
//   cfg_parity_en_i   append a parity bit
//   cfg_parity_odd_i  0=even, 1=odd parity
//   cfg_stop2_i       0=one stop bit, 1=two stop bits
//   tx_data_i[7:0]    byte from the FIFO; only the low N bits are sent
//   tx_valid_i        FIFO has a byte
//   tx_ready_o        this block pops a byte this cycle
//   tx_o              serial line, registered, idle high
//   busy_o            a frame is in progress
// ---------------------------------------------------------------------------
module uart_tx_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_parity_en_i,
  input  logic        cfg_parity_odd_i,
  input  logic        cfg_stop2_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Keeps only the bits that belong to the selected character length.
  function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] bits);
    logic [DATA_W-1:0] m;
    case (bits)
      2'd0:    m = 8'h1F;
      2'd1:    m = 8'h3F;
      2'd2:    m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Parity over the transmitted data bits only; odd parity inverts it.
  function automatic logic parity_bit(input logic [DATA_W-1:0] data,
                                      input logic [1:0]        bits,
                                      input logic              odd);
    return (^(data & data_mask(bits))) ^ odd;
  endfunction

  // Control state (reset)
  state_t      state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;

  // Per-frame data and configuration snapshot (not reset)
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [15:0]       div_q;
  logic [1:0]        bits_q;
  logic              par_en_q;
  logic              par_bit_q;
  logic              stop2_q;

  logic bit_end;
  logic last_data;
  logic last_stop;
  logic accept;

  // Handshake and status
  // The last stop-bit cycle also accepts so the next start bit follows with
  // no idle gap. Reset blocks the pop so a byte is never lost while the frame
  // state is being cleared.
  assign bit_end    = (div_cnt_q == div_q);
  assign last_data  = (bit_cnt_q == {1'b1, bits_q});
  assign last_stop  = (state_q == STOP) && bit_end && (stop_cnt_q == stop2_q);
  assign tx_ready_o = !rst_i && cfg_en_i && ((state_q == IDLE) || last_stop);
  assign accept     = tx_valid_i && tx_ready_o;
  assign busy_o     = (state_q != IDLE);
  assign tx_o       = tx_q;

  // Next-state and line value
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    shift_d    = shift_q;

    // Bit period counter free-runs 0..div inside a frame and idles at zero.
    if (state_q == IDLE) begin
      div_cnt_d = 16'd0;
    end else if (bit_end) begin
      div_cnt_d = 16'd0;
    end else begin
      div_cnt_d = div_cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = tx_data_i;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (last_data) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            // The current bit sits in shift_q[0]; the next one is shift_q[1].
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[DATA_W-1:1]};
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q != stop2_q) begin
            stop_cnt_d = 1'b1;
            tx_d       = 1'b1;
          end else if (accept) begin
            state_d = START;
            tx_d    = 1'b0;
            shift_d = tx_data_i;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_cnt_q  <= 16'd0;
      bit_cnt_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // Frame snapshot: configuration is frozen on accept so register writes
  // during a frame only take effect from the next byte.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    if (accept) begin
      div_q     <= cfg_div_i;
      bits_q    <= cfg_bits_i;
      par_en_q  <= cfg_parity_en_i;
      par_bit_q <= parity_bit(tx_data_i, cfg_bits_i, cfg_parity_odd_i);
      stop2_q   <= cfg_stop2_i;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Self-checking bench for uart_tx_serializer. Inputs change on the falling
// edge; outputs are sampled after it. Each driven byte pushes its expected
// serial line values (one entry per clock) into a queue that a monitor pops
// once the handshake has happened.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_parity_en_i;
  logic        cfg_parity_odd_i;
  logic        cfg_stop2_i;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic        tx_o;
  logic        busy_o;

  uart_tx_serializer dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .tx_data_i        (tx_data_i),
    .tx_valid_i       (tx_valid_i),
    .tx_ready_o       (tx_ready_o),
    .tx_o             (tx_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bits;
    logic        pen;
    logic        podd;
    logic        stop2;
    logic [15:0] div;
    logic [7:0]  data;
    logic        par;   // expected parity bit on the line
    int          len;   // expected busy cycles
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   hs_cnt = 0;
  bit   active = 1'b0;
  bit   mon_on = 1'b0;
  logic exp_q[$];
  logic mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Line monitor / scoreboard consumer
  always @(negedge clk) begin
    #2;
    if (mon_on) begin
      if (active && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("tx_bit", {31'd0, tx_o}, {31'd0, mon_e});
      end else if (!active) begin
        chk("tx_idle", {31'd0, tx_o}, 32'd1);
      end
      if (exp_q.size() == 0) active = 1'b0;
      if (rst_i) begin
        exp_q.delete();
        active = 1'b0;
      end
      if (tx_valid_i && tx_ready_o) begin
        hs_cnt++;
        active = 1'b1;
      end
    end
  end

  task automatic push_frame(input vec_t v);
    int n;
    n = int'(v.bits) + 5;
    repeat (int'(v.div) + 1) exp_q.push_back(1'b0);
    for (int b = 0; b < n; b++)
      repeat (int'(v.div) + 1) exp_q.push_back(v.data[b]);
    if (v.pen) repeat (int'(v.div) + 1) exp_q.push_back(v.par);
    repeat ((int'(v.div) + 1) * (v.stop2 ? 2 : 1)) exp_q.push_back(1'b1);
  endtask

  // Called just after a falling edge with the block idle; returns one cycle
  // after the handshake with tx_valid_i already dropped.
  task automatic start_frame(input vec_t v);
    int hs0;
    cfg_bits_i       = v.bits;
    cfg_parity_en_i  = v.pen;
    cfg_parity_odd_i = v.podd;
    cfg_stop2_i      = v.stop2;
    cfg_div_i        = v.div;
    cfg_en_i         = 1'b1;
    tx_data_i        = v.data;
    tx_valid_i       = 1'b1;
    push_frame(v);
    hs0 = hs_cnt;
    for (int k = 0; k < 8 && hs_cnt == hs0; k++) @(negedge clk);
    tx_valid_i = 1'b0;
    chk("accept", hs_cnt - hs0, 32'd1);
  endtask

  task automatic wait_end(output int n);
    n = 0;
    while (busy_o && n < 70000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input vec_t v, input string name);
    int n;
    start_frame(v);
    wait_end(n);
    chk(name, n, v.len);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("busy_after", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int   n;
    int   hs0;

    tbl[0] = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd3, 8'hA5, 1'b0, 40};  // 8N1
    tbl[1] = '{2'd2, 1'b1, 1'b0, 1'b1, 16'd0, 8'h55, 1'b0, 11};  // 7E2
    tbl[2] = '{2'd2, 1'b1, 1'b1, 1'b1, 16'd0, 8'h55, 1'b1, 11};  // 7O2
    tbl[3] = '{2'd0, 1'b1, 1'b1, 1'b0, 16'd1, 8'hFF, 1'b0, 16};  // 5O1
    tbl[4] = '{2'd1, 1'b1, 1'b0, 1'b0, 16'd2, 8'h2C, 1'b1, 27};  // 6E1
    tbl[5] = '{2'd3, 1'b1, 1'b1, 1'b1, 16'd0, 8'h00, 1'b1, 12};  // 8O2

    rst_i            = 1'b1;
    cfg_en_i         = 1'b1;
    cfg_div_i        = 16'd0;
    cfg_bits_i       = 2'd3;
    cfg_parity_en_i  = 1'b0;
    cfg_parity_odd_i = 1'b0;
    cfg_stop2_i      = 1'b0;
    tx_data_i        = 8'h00;
    tx_valid_i       = 1'b0;

    // Reset state
    @(negedge clk);
    #1 chk("rst_ready_gated", {31'd0, tx_ready_o}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i    = 1'b0;
    cfg_en_i = 1'b0;
    #1 chk("idle_ready_en0", {31'd0, tx_ready_o}, 32'd0);
    cfg_en_i = 1'b1;
    mon_on   = 1'b1;
    #0 chk("idle_ready_en1", {31'd0, tx_ready_o}, 32'd1);
    @(negedge clk);

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i], $sformatf("frame_len[%0d]", i));
      @(negedge clk);
    end

    // Back-to-back 8N1 div=0: 0x00 then 0xFF, no idle cycle between
    v = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 10};
    cfg_bits_i = v.bits; cfg_parity_en_i = 1'b0; cfg_stop2_i = 1'b0;
    cfg_div_i  = 16'd0;  cfg_en_i = 1'b1;
    tx_data_i  = 8'h00;  tx_valid_i = 1'b1;
    push_frame(v);
    v.data = 8'hFF;
    push_frame(v);
    hs0 = hs_cnt;
    #1 chk("b2b_ready[0]", {31'd0, tx_ready_o}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1)  tx_data_i  = 8'hFF;
      if (k == 11) tx_valid_i = 1'b0;
      #1 chk($sformatf("b2b_ready[%0d]", k), {31'd0, tx_ready_o},
             (k == 10 || k == 20) ? 32'd1 : 32'd0);
    end
    chk("b2b_handshakes", hs_cnt - hs0, 32'd2);
    @(negedge clk);
    chk("b2b_busy_end", {31'd0, busy_o}, 32'd0);
    chk("b2b_queue_empty", exp_q.size(), 32'd0);
    @(negedge clk);

    // Divider change mid-frame applies to the next frame only
    v = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd2, 8'h3C, 1'b0, 30};
    start_frame(v);
    n = 0;
    while (busy_o && n < 1000) begin
      n++;
      if (n == 5) cfg_div_i = 16'd9;
      @(negedge clk);
    end
    chk("div_change_len", n, 32'd30);
    v = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd9, 8'h81, 1'b0, 100};
    send_frame(v, "div9_len");
    @(negedge clk);

    // Enable dropped mid-frame: frame completes, nothing new is popped
    v = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd2, 8'hC3, 1'b0, 30};
    start_frame(v);
    hs0 = hs_cnt;
    n = 0;
    while (busy_o && n < 1000) begin
      n++;
      if (n == 4) begin
        cfg_en_i   = 1'b0;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h99;
      end
      @(negedge clk);
    end
    chk("en_drop_len", n, 32'd30);
    #1 chk("en_drop_ready", {31'd0, tx_ready_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("en_drop_no_pop", hs_cnt - hs0, 32'd0);
    chk("en_drop_busy", {31'd0, busy_o}, 32'd0);
    tx_valid_i = 1'b0;
    @(negedge clk);
    // Enable and valid rise together: accepted on that edge
    v = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd2, 8'h5A, 1'b0, 30};
    send_frame(v, "en_valid_together_len");
    @(negedge clk);

    // Reset in the middle of DATA
    v = '{2'd3, 1'b0, 1'b0, 1'b0, 16'd2, 8'hF0, 1'b0, 30};
    start_frame(v);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    hs0 = hs_cnt;
    rst_i      = 1'b1;
    tx_valid_i = 1'b1;
    tx_data_i  = 8'h11;
    #1 chk("rst_no_pop", {31'd0, tx_ready_o}, 32'd0);
    @(negedge clk);
    rst_i      = 1'b0;
    tx_valid_i = 1'b0;
    chk("rst_mid_tx", {31'd0, tx_o}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    #1 chk("rst_mid_ready_en1", {31'd0, tx_ready_o}, 32'd1);
    cfg_en_i = 1'b0;
    #1 chk("rst_mid_ready_en0", {31'd0, tx_ready_o}, 32'd0);
    chk("rst_mid_no_pop", hs_cnt - hs0, 32'd0);
    cfg_en_i = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
